pll_lock_supervisor: RTL and testbench

//  Drives the reset input of the video PLL and consumes its asynchronous locked output. Produces the

---
 rtl/pll_sup_pkg.sv | 39 +++
 rtl/sync_2ff.sv | 19 +
 rtl/pll_lock_supervisor.sv | 126 ++++++++++++
 tb/tb_pll_lock_supervisor.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// Shared definitions for the PLL lock supervisor: state encodings,
// default cycle counts and the state-to-output decode.
package pll_sup_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_PLL_RST   = 3'd0;
    localparam logic [STATE_W-1:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [STATE_W-1:0] ST_STABLE    = 3'd2;
    localparam logic [STATE_W-1:0] ST_RUN       = 3'd3;
    localparam logic [STATE_W-1:0] ST_FAIL      = 3'd4;

    localparam int DEF_PLL_RST_CYCLES     = 16;
    localparam int DEF_LOCK_TIMEOUT       = 100000;
    localparam int DEF_LOCK_STABLE_CYCLES = 1024;
    localparam int DEF_MAX_RETRIES        = 3;
    localparam int DEF_CNT_W              = 20;

    localparam logic [7:0] LOSS_CNT_MAX = 8'hFF;

    typedef struct packed {
        logic pll_rst;
        logic sys_rst;
        logic ready;
        logic fail;
    } sup_out_t;

    // Output levels implied by a state; registered by the caller so the
    // outputs change on the same edge that enters the state.
    function automatic sup_out_t decode_outputs(input logic [STATE_W-1:0] st);
        sup_out_t o;
        o.pll_rst = (st == ST_PLL_RST);
        o.sys_rst = (st != ST_RUN);
        o.ready   = (st == ST_RUN);
        o.fail    = (st == ST_FAIL);
        return o;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for signals crossing into the local clock domain.
// The data path carries no reset so the flops can be placed as a pair.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Capture the asynchronous input and let the first stage settle a cycle
    always_ff @(posedge clk) begin
        meta <= d;
        q    <= meta;
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, waits for a stable lock with
// timeout and bounded retries, and drives the downstream reset/ready flags.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int PLL_RST_CYCLES     = DEF_PLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT       = DEF_LOCK_TIMEOUT,
    parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int MAX_RETRIES        = DEF_MAX_RETRIES,
    parameter int CNT_W              = DEF_CNT_W
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked,
    input  logic       retry_req,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [7:0] loss_cnt
);

    logic               locked_s;
    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [7:0]         retry_cnt;
    logic [7:0]         retry_cnt_nxt;
    logic               loss_inc;
    sup_out_t           out_nxt;

    sync_2ff #(
        .WIDTH(1)
    ) u_locked_sync (
        .clk(refclk),
        .d  (locked),
        .q  (locked_s)
    );

    // Sequencing decisions; lock checks take precedence over counter expiry
    always_comb begin
        state_nxt     = state;
        retry_cnt_nxt = retry_cnt;
        loss_inc      = 1'b0;
        case (state)
            ST_PLL_RST: begin
                if (cnt == CNT_W'(PLL_RST_CYCLES - 1)) begin
                    state_nxt = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_nxt = ST_STABLE;
                end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    if (retry_cnt == 8'(MAX_RETRIES)) begin
                        state_nxt = ST_FAIL;
                    end else begin
                        retry_cnt_nxt = retry_cnt + 8'd1;
                        state_nxt     = ST_PLL_RST;
                    end
                end
            end
            ST_STABLE: begin
                if (!locked_s) begin
                    state_nxt = ST_WAIT_LOCK;
                end else if (cnt == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
                    state_nxt     = ST_RUN;
                    retry_cnt_nxt = '0;
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    state_nxt = ST_PLL_RST;
                    loss_inc  = 1'b1;
                end
            end
            ST_FAIL: begin
                if (retry_req) begin
                    state_nxt     = ST_PLL_RST;
                    retry_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt = ST_PLL_RST;
            end
        endcase
    end

    // Shared cycle counter: cleared on any state change, idle in RUN and FAIL
    always_comb begin
        cnt_nxt = '0;
        if ((state_nxt == state) &&
            ((state == ST_PLL_RST) || (state == ST_WAIT_LOCK) || (state == ST_STABLE))) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    assign out_nxt = decode_outputs(state_nxt);

    // State, counters and outputs registered together from the next state
    always_ff @(posedge refclk) begin
        if (rst) begin
            state     <= ST_PLL_RST;
            cnt       <= '0;
            retry_cnt <= '0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            fail      <= 1'b0;
            loss_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            retry_cnt <= retry_cnt_nxt;
            pll_rst   <= out_nxt.pll_rst;
            sys_rst   <= out_nxt.sys_rst;
            ready     <= out_nxt.ready;
            fail      <= out_nxt.fail;
            if (loss_inc && (loss_cnt != LOSS_CNT_MAX)) begin
                loss_cnt <= loss_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor with a behavioural reference
// model of the lock sequence and directed plus randomized stimulus.
module tb_pll_lock_supervisor;

    localparam int P_RST  = 4;
    localparam int P_TO   = 16;
    localparam int P_STAB = 8;
    localparam int P_MAXR = 2;

    logic       refclk;
    logic       rst;
    logic       locked;
    logic       retry_req;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fail;
    logic [7:0] loss_cnt;

    int checks = 0;
    int errors = 0;
    logic [11:0] obs;

    pll_lock_supervisor #(
        .PLL_RST_CYCLES    (P_RST),
        .LOCK_TIMEOUT      (P_TO),
        .LOCK_STABLE_CYCLES(P_STAB),
        .MAX_RETRIES       (P_MAXR),
        .CNT_W             (20)
    ) dut (
        .refclk   (refclk),
        .rst      (rst),
        .locked   (locked),
        .retry_req(retry_req),
        .pll_rst  (pll_rst),
        .sys_rst  (sys_rst),
        .ready    (ready),
        .fail     (fail),
        .loss_cnt (loss_cnt)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    // ---------------- reference model ----------------
    typedef enum {M_PULSE, M_AWAIT, M_SETTLE, M_RUNNING, M_FAILED} mph_t;
    mph_t m_ph    = M_PULSE;
    int   m_t     = 0;
    int   m_tries = 0;
    int   m_loss  = 0;
    logic m_q1    = 1'b0;
    logic m_q2    = 1'b0;

    always @(posedge refclk) begin : ref_model
        mph_t ph;
        int   t;
        int   tries;
        int   loss;
        logic ls;
        ls    = m_q2;
        ph    = m_ph;
        t     = m_t;
        tries = m_tries;
        loss  = m_loss;
        if (rst) begin
            ph = M_PULSE; t = 0; tries = 0; loss = 0;
        end else begin
            case (ph)
                M_PULSE: begin
                    t++;
                    if (t == P_RST) begin ph = M_AWAIT; t = 0; end
                end
                M_AWAIT: begin
                    if (ls) begin
                        ph = M_SETTLE; t = 0;
                    end else begin
                        t++;
                        if (t == P_TO) begin
                            t = 0;
                            if (tries == P_MAXR) ph = M_FAILED;
                            else begin tries++; ph = M_PULSE; end
                        end
                    end
                end
                M_SETTLE: begin
                    if (!ls) begin
                        ph = M_AWAIT; t = 0;
                    end else begin
                        t++;
                        if (t == P_STAB) begin ph = M_RUNNING; t = 0; tries = 0; end
                    end
                end
                M_RUNNING: begin
                    if (!ls) begin
                        ph = M_PULSE; t = 0;
                        if (loss < 255) loss++;
                    end
                end
                M_FAILED: begin
                    if (retry_req) begin ph = M_PULSE; t = 0; tries = 0; end
                end
                default: ;
            endcase
        end
        m_ph    <= ph;
        m_t     <= t;
        m_tries <= tries;
        m_loss  <= loss;
        m_q2    <= m_q1;
        m_q1    <= locked;
    end

    function automatic logic [11:0] model_vec();
        return {m_ph == M_PULSE, m_ph != M_RUNNING, m_ph == M_RUNNING,
                m_ph == M_FAILED, 8'(m_loss)};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; locked = 1'b1; retry_req = 1'b0;
        repeat (3) @(negedge refclk);
        obs = {pll_rst, sys_rst, ready, fail, loss_cnt};
        checks++;
        if (obs !== 12'hC00) begin
            errors++; $display("FAIL reset_values got=%h exp=%h", obs, 12'hC00);
        end
        checks++;
        if (obs !== model_vec()) begin
            errors++; $display("FAIL reset_model got=%h exp=%h", obs, model_vec());
        end
    endtask

    task automatic test_lock_first();
        int first_low = -1;
        int first_ready = -1;
        rst = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge refclk);
            obs = {pll_rst, sys_rst, ready, fail, loss_cnt};
            checks++;
            if (obs !== model_vec()) begin
                errors++; $display("FAIL lock_first cyc=%0d got=%h exp=%h", k, obs, model_vec());
            end
            if (first_low < 0 && pll_rst === 1'b0) first_low = k;
            if (first_ready < 0 && ready === 1'b1) first_ready = k;
        end
        checks++;
        if (first_low != P_RST) begin
            errors++; $display("FAIL pll_rst_width got=%0d exp=%0d", first_low, P_RST);
        end
        checks++;
        if (first_ready != P_RST + 1 + P_STAB) begin
            errors++; $display("FAIL ready_latency got=%0d exp=%0d", first_ready, P_RST + 1 + P_STAB);
        end
    endtask

    task automatic test_no_lock();
        int pulses = 0;
        int first_fail = -1;
        logic prev;
        rst = 1'b1; locked = 1'b0;
        repeat (3) @(negedge refclk);
        rst = 1'b0;
        prev = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            @(negedge refclk);
            obs = {pll_rst, sys_rst, ready, fail, loss_cnt};
            checks++;
            if (obs !== model_vec()) begin
                errors++; $display("FAIL no_lock cyc=%0d got=%h exp=%h", k, obs, model_vec());
            end
            if (pll_rst === 1'b1 && prev !== 1'b1) pulses++;
            prev = pll_rst;
            if (first_fail < 0 && fail === 1'b1) first_fail = k;
        end
        checks++;
        if (pulses != P_MAXR + 1) begin
            errors++; $display("FAIL attempt_count got=%0d exp=%0d", pulses, P_MAXR + 1);
        end
        checks++;
        if (first_fail != (P_MAXR + 1) * (P_RST + P_TO)) begin
            errors++; $display("FAIL fail_entry got=%0d exp=%0d", first_fail, (P_MAXR + 1) * (P_RST + P_TO));
        end
        obs = {pll_rst, sys_rst, ready, fail, loss_cnt};
        checks++;
        if (obs !== 12'h500) begin
            errors++; $display("FAIL fail_outputs got=%h exp=%h", obs, 12'h500);
        end
    endtask

    task automatic test_retry();
        int k = 0;
        locked = 1'b1;
        repeat (4) @(negedge refclk);
        retry_req = 1'b1;
        @(negedge refclk);
        retry_req = 1'b0;
        obs = {pll_rst, sys_rst, ready, fail, loss_cnt};
        checks++;
        if (obs !== 12'hC00) begin
            errors++; $display("FAIL retry_exit got=%h exp=%h", obs, 12'hC00);
        end
        while (m_ph != M_RUNNING && k < 40) begin
            @(negedge refclk);
            k++;
            obs = {pll_rst, sys_rst, ready, fail, loss_cnt};
            checks++;
            if (obs !== model_vec()) begin
                errors++; $display("FAIL retry_seq cyc=%0d got=%h exp=%h", k, obs, model_vec());
            end
        end
        checks++;
        if (ready !== 1'b1) begin
            errors++; $display("FAIL retry_reach_run got=%b exp=1", ready);
        end
        retry_req = 1'b1;
        @(negedge refclk);
        retry_req = 1'b0;
        for (int j = 0; j < 10; j++) begin
            obs = {pll_rst, sys_rst, ready, fail, loss_cnt};
            checks++;
            if (obs !== 12'h200) begin
                errors++; $display("FAIL retry_in_run cyc=%0d got=%h exp=%h", j, obs, 12'h200);
            end
            @(negedge refclk);
        end
    endtask

    task automatic test_lock_loss();
        for (int it = 0; it < 300; it++) begin
            int k = 0;
            locked = 1'b0;
            for (int j = 0; j < 3; j++) begin
                @(negedge refclk);
                locked = 1'b1;
                obs = {pll_rst, sys_rst, ready, fail, loss_cnt};
                checks++;
                if (obs !== model_vec()) begin
                    errors++; $display("FAIL loss_drop it=%0d got=%h exp=%h", it, obs, model_vec());
                end
            end
            if (it == 0) begin
                checks++;
                if (loss_cnt !== 8'd1) begin
                    errors++; $display("FAIL loss_first got=%0d exp=1", loss_cnt);
                end
            end
            while (m_ph != M_RUNNING && k < 40) begin
                @(negedge refclk);
                k++;
                obs = {pll_rst, sys_rst, ready, fail, loss_cnt};
                checks++;
                if (obs !== model_vec()) begin
                    errors++; $display("FAIL loss_reseq it=%0d got=%h exp=%h", it, obs, model_vec());
                end
            end
            if (k >= 40) begin
                checks++; errors++;
                $display("FAIL loss_timeout it=%0d got=not_run exp=run", it);
            end
        end
        checks++;
        if (loss_cnt !== 8'd255) begin
            errors++; $display("FAIL loss_saturate got=%0d exp=255", loss_cnt);
        end
    endtask

    task automatic test_glitch();
        int k = 0;
        int first_ready = -1;
        locked = 1'b0;
        @(negedge refclk);
        locked = 1'b1;
        while (!(m_ph == M_SETTLE && m_t == 3) && k < 30) begin
            @(negedge refclk);
            k++;
        end
        if (k >= 30) begin
            checks++; errors++;
            $display("FAIL glitch_setup got=timeout exp=stable");
        end
        locked = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            @(negedge refclk);
            locked = 1'b1;
            obs = {pll_rst, sys_rst, ready, fail, loss_cnt};
            checks++;
            if (obs !== model_vec()) begin
                errors++; $display("FAIL glitch cyc=%0d got=%h exp=%h", j, obs, model_vec());
            end
            if (first_ready < 0 && ready === 1'b1) first_ready = j;
        end
        checks++;
        if (first_ready != 4 + P_STAB) begin
            errors++; $display("FAIL glitch_ready got=%0d exp=%0d", first_ready, 4 + P_STAB);
        end
    endtask

    task automatic test_rst_mid();
        int k = 0;
        locked = 1'b0;
        @(negedge refclk);
        locked = 1'b1;
        while (m_ph != M_SETTLE && k < 30) begin @(negedge refclk); k++; end
        rst = 1'b1;
        @(negedge refclk);
        rst = 1'b0;
        obs = {pll_rst, sys_rst, ready, fail, loss_cnt};
        checks++;
        if (obs !== 12'hC00) begin
            errors++; $display("FAIL rst_in_stable got=%h exp=%h", obs, 12'hC00);
        end
        locked = 1'b0;
        k = 0;
        while (m_ph != M_FAILED && k < 100) begin
            @(negedge refclk);
            k++;
            obs = {pll_rst, sys_rst, ready, fail, loss_cnt};
            checks++;
            if (obs !== model_vec()) begin
                errors++; $display("FAIL rst_mid_seq cyc=%0d got=%h exp=%h", k, obs, model_vec());
            end
        end
        rst = 1'b1;
        @(negedge refclk);
        rst = 1'b0;
        obs = {pll_rst, sys_rst, ready, fail, loss_cnt};
        checks++;
        if (obs !== 12'hC00) begin
            errors++; $display("FAIL rst_in_fail got=%h exp=%h", obs, 12'hC00);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 19) == 0) locked = ~locked;
            retry_req = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 299) == 0);
            @(negedge refclk);
            obs = {pll_rst, sys_rst, ready, fail, loss_cnt};
            checks++;
            if (obs !== model_vec()) begin
                errors++; $display("FAIL random cyc=%0d got=%h exp=%h", k, obs, model_vec());
            end
        end
        retry_req = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_lock_first();
        test_no_lock();
        test_retry();
        test_lock_loss();
        test_glitch();
        test_rst_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
